// File: rtl/op_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | op_loader_if : UART rx line plus opram write / core status bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface op_loader_if;
  logic       rx;
  logic       write;
  logic [7:0] writeaddr;
  logic [7:0] writeop;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  rx,
    output write, writeaddr, writeop, cpu_rst_n, busy, done, err
  );

  modport master (
    output rx,
    input  write, writeaddr, writeop, cpu_rst_n, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/op_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | op_loader : 8N1 UART program loader feeding opram_control writes      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module op_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_CLKS = 4096,
  parameter bit BOOT_HOLD    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  op_loader_if.slave bus
);

  localparam int BCW = $clog2(CLKS_PER_BIT) + 1;
  localparam int TCW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [BCW-1:0] HALF_BIT = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] FULL_BIT = BCW'(CLKS_PER_BIT - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]     HEADER   = 8'hA5;

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_COUNT = 3'd1;
  localparam logic [2:0] P_DATA  = 3'd2;
  localparam logic [2:0] P_CSUM  = 3'd3;
  localparam logic [2:0] P_DONE  = 3'd4;
  localparam logic [2:0] P_ERR   = 3'd5;

  // rx synchronizer plus one extra stage for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  logic [1:0]     u_state_q, u_state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           byte_valid, frame_err;
  logic [7:0]     rx_byte;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      u_state_q <= U_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      u_state_q <= u_state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    u_state_d = u_state_q;
    case (u_state_q)
      U_IDLE:  if (rx_prev_q && !rx_sync_q) u_state_d = U_START;
      U_START: if (bit_cnt_q == HALF_BIT) u_state_d = rx_sync_q ? U_IDLE : U_DATA;
      U_DATA:  if (bit_cnt_q == FULL_BIT && bit_idx_q == 3'd7) u_state_d = U_STOP;
      U_STOP:  if (bit_cnt_q == FULL_BIT) u_state_d = U_IDLE;
      default: u_state_d = U_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (u_state_q)
      U_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
      end
      U_START: if (bit_cnt_q == HALF_BIT) bit_cnt_d = '0;
      U_DATA: begin
        if (bit_cnt_q == FULL_BIT) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          shift_d   = {rx_sync_q, shift_q[7:1]};
        end
      end
      U_STOP: if (bit_cnt_q == FULL_BIT) bit_cnt_d = '0;
      default: bit_cnt_d = '0;
    endcase
  end

  always_comb begin
    byte_valid = (u_state_q == U_STOP) && (bit_cnt_q == FULL_BIT) &&  rx_sync_q;
    frame_err  = (u_state_q == U_STOP) && (bit_cnt_q == FULL_BIT) && !rx_sync_q;
    rx_byte    = shift_q;
  end

  logic [2:0]     p_state_q, p_state_d;
  logic [8:0]     remain_q, remain_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     sum_q, sum_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           write_q, write_d;
  logic [7:0]     waddr_q, waddr_d;
  logic [7:0]     wop_q, wop_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           crst_q, crst_d;
  logic           in_pkt, timeout, abort, hdr_seen;

  always_comb begin
    in_pkt   = (p_state_q == P_COUNT) || (p_state_q == P_DATA) || (p_state_q == P_CSUM);
    // a byte arriving on the expiry cycle takes priority over the timeout
    timeout  = in_pkt && !byte_valid && (tmo_q == TMO_LAST);
    abort    = in_pkt && (frame_err || timeout);
    hdr_seen = byte_valid && (rx_byte == HEADER);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_state_q <= P_IDLE;
      remain_q  <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      write_q   <= 1'b0;
      waddr_q   <= '0;
      wop_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      crst_q    <= ~BOOT_HOLD;
    end else begin
      p_state_q <= p_state_d;
      remain_q  <= remain_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      write_q   <= write_d;
      waddr_q   <= waddr_d;
      wop_q     <= wop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      crst_q    <= crst_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    case (p_state_q)
      P_IDLE, P_DONE, P_ERR: if (hdr_seen) p_state_d = P_COUNT;
      P_COUNT: begin
        if (byte_valid) p_state_d = P_DATA;
        else if (abort) p_state_d = P_ERR;
      end
      P_DATA: begin
        if (byte_valid && remain_q == 9'd1) p_state_d = P_CSUM;
        else if (abort) p_state_d = P_ERR;
      end
      P_CSUM: begin
        if (byte_valid) p_state_d = (rx_byte == sum_q) ? P_DONE : P_ERR;
        else if (abort) p_state_d = P_ERR;
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  always_comb begin
    remain_d = remain_q;
    addr_d   = addr_q;
    sum_d    = sum_q;
    tmo_d    = (in_pkt && !byte_valid) ? tmo_q + 1'b1 : '0;
    write_d  = 1'b0;
    waddr_d  = waddr_q;
    wop_d    = wop_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    crst_d   = crst_q;
    case (p_state_q)
      P_IDLE, P_DONE, P_ERR: begin
        // done was raised on the previous edge, so the core leaves reset one clk later
        if (p_state_q == P_DONE) crst_d = 1'b1;
        if (hdr_seen) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
          crst_d = 1'b0;
        end
      end
      P_COUNT: begin
        if (byte_valid) begin
          remain_d = {rx_byte == 8'h00, rx_byte};
          addr_d   = '0;
          sum_d    = '0;
        end
      end
      P_DATA: begin
        if (byte_valid) begin
          write_d  = 1'b1;
          waddr_d  = addr_q;
          wop_d    = rx_byte;
          sum_d    = sum_q + rx_byte;
          addr_d   = addr_q + 8'd1;
          remain_d = remain_q - 9'd1;
        end
      end
      P_CSUM: begin
        if (byte_valid) begin
          busy_d = 1'b0;
          if (rx_byte == sum_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (abort) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign bus.write     = write_q;
  assign bus.writeaddr = waddr_q;
  assign bus.writeop   = wop_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cpu_rst_n = crst_q;

endmodule
`default_nettype wire

// File: tb/tb_op_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_op_loader : self-checking bench for op_loader                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_op_loader;
  localparam int CPB = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  op_loader_if bus ();

  op_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO),
    .BOOT_HOLD   (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // write-strobe capture and rise-time tracking of done / cpu_rst_n
  logic [7:0] wa_q[$];
  logic [7:0] wo_q[$];
  int   done_rise = -1;
  int   crst_rise = -1;
  logic done_prev = 1'b0;
  logic crst_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.write === 1'b1) begin
      wa_q.push_back(bus.writeaddr);
      wo_q.push_back(bus.writeop);
    end
    if (bus.done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
    if (bus.cpu_rst_n === 1'b1 && crst_prev !== 1'b1) crst_rise = cyc;
    done_prev = bus.done;
    crst_prev = bus.cpu_rst_n;
  end

  // reference: parse a byte stream by the packet rules
  logic [7:0] exp_a[$];
  logic [7:0] exp_o[$];
  logic       exp_done, exp_err;

  task automatic model_stream(input logic [7:0] s[$]);
    int i = 0;
    int n;
    int total;
    exp_a.delete();
    exp_o.delete();
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
      end else begin
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = (s[i+1] == 8'h00) ? 256 : int'(s[i+1]);
        total = 0;
        for (int k = 0; k < n; k++) begin
          exp_a.push_back(k[7:0]);
          exp_o.push_back(s[i+2+k]);
          total += int'(s[i+2+k]);
        end
        if (int'(s[i+2+n]) == (total % 256)) exp_done = 1'b1;
        else                                 exp_err  = 1'b1;
        i += 3 + n;
      end
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wo_q.delete();
    done_rise = -1;
    crst_rise = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) bus.rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) bus.rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) bus.rx = stop;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) bus.rx = 1'b1;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int max_gap);
    foreach (s[k]) begin
      send_byte(s[k], 1'b1);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.write, bus.writeaddr, bus.writeop, bus.busy, bus.done, bus.err, bus.cpu_rst_n} !== 21'd0) begin
      errors++;
      $display("FAIL reset_vals: got w=%b a=%h o=%h busy=%b done=%b err=%b crst=%b want all 0",
               bus.write, bus.writeaddr, bus.writeop, bus.busy, bus.done, bus.err, bus.cpu_rst_n);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.cpu_rst_n !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got crst=%b busy=%b want 0 0", bus.cpu_rst_n, bus.busy);
    end
  endtask

  task automatic test_good_packet();
    logic [7:0] s[$];
    logic [7:0] ea[$];
    logic [7:0] eo[$];
    clear_mon();
    s  = '{8'hA5, 8'h03, 8'h10, 8'h21, 8'h32, 8'h63};
    ea = '{8'h00, 8'h01, 8'h02};
    eo = '{8'h10, 8'h21, 8'h32};
    send_stream(s, 4);
    checks++;
    if (wa_q.size() != 3) begin
      errors++;
      $display("FAIL good_nwrites: got %0d want 3", wa_q.size());
    end
    for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== ea[k] || wo_q[k] !== eo[k]) begin
        errors++;
        $display("FAIL good_write%0d: got %h=%h want %h=%h", k, wa_q[k], wo_q[k], ea[k], eo[k]);
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL good_status: got done=%b err=%b busy=%b crst=%b want 1 0 0 1",
               bus.done, bus.err, bus.busy, bus.cpu_rst_n);
    end
    checks++;
    if (crst_rise - done_rise !== 1) begin
      errors++;
      $display("FAIL good_crst_lag: got %0d clks want 1", crst_rise - done_rise);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[$];
    clear_mon();
    s = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send_stream(s, 4);
    checks++;
    if (wa_q.size() != 2) begin
      errors++;
      $display("FAIL badck_nwrites: got %0d want 2", wa_q.size());
    end
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_rst_n !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL badck_status: got err=%b done=%b crst=%b busy=%b want 1 0 0 0",
               bus.err, bus.done, bus.cpu_rst_n, bus.busy);
    end
  endtask

  task automatic test_leading_junk();
    logic [7:0] s[$];
    clear_mon();
    // 1-clk low glitch must be rejected at the start-bit recheck
    @(negedge clk) bus.rx = 1'b0;
    @(negedge clk) bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7E};
    send_stream(s, 4);
    checks++;
    if (wa_q.size() != 1) begin
      errors++;
      $display("FAIL junk_nwrites: got %0d want 1", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 8'h00 || wo_q[0] !== 8'h7E) begin
        errors++;
        $display("FAIL junk_write: got %h=%h want 00=7e", wa_q[0], wo_q[0]);
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL junk_status: got done=%b err=%b want 1 0", bus.done, bus.err);
    end
    send_byte(8'h33, 1'b0);
    send_byte(8'h55, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || wa_q.size() != 1 || bus.cpu_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_frame_ignored: got done=%b err=%b nwr=%0d crst=%b want 1 0 1 1",
               bus.done, bus.err, wa_q.size(), bus.cpu_rst_n);
    end
  endtask

  task automatic test_wrap_256();
    logic [7:0] s[$];
    clear_mon();
    s = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) s.push_back(i[7:0]);
    s.push_back(8'h80);
    model_stream(s);
    send_stream(s, 2);
    checks++;
    if (wa_q.size() != exp_a.size()) begin
      errors++;
      $display("FAIL wrap_nwrites: got %0d want %0d", wa_q.size(), exp_a.size());
    end
    for (int k = 0; k < exp_a.size() && k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== exp_a[k] || wo_q[k] !== exp_o[k]) begin
        errors++;
        $display("FAIL wrap_write%0d: got %h=%h want %h=%h", k, wa_q[k], wo_q[k], exp_a[k], exp_o[k]);
      end
    end
    checks++;
    if (bus.done !== exp_done || bus.err !== exp_err || bus.cpu_rst_n !== exp_done) begin
      errors++;
      $display("FAIL wrap_status: got done=%b err=%b crst=%b want %b %b %b",
               bus.done, bus.err, bus.cpu_rst_n, exp_done, exp_err, exp_done);
    end
  endtask

  task automatic test_timeout();
    int w;
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (50) @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: got err=%b busy=%b want 0 1", bus.err, bus.busy);
    end
    w = 0;
    while (w < 40 && bus.err !== 1'b1) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: got err=%b busy=%b done=%b want 1 0 0", bus.err, bus.busy, bus.done);
    end
    checks++;
    if (wa_q.size() != 1) begin
      errors++;
      $display("FAIL tmo_nwrites: got %0d want 1", wa_q.size());
    end
  endtask

  task automatic test_frame_and_reset();
    logic [7:0] s[$];
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL frame_abort: got err=%b busy=%b done=%b nwr=%0d want 1 0 0 0",
               bus.err, bus.busy, bus.done, wa_q.size());
    end
    clear_mon();
    s = '{8'hA5, 8'h03, 8'h10, 8'h21};
    send_stream(s, 2);
    @(negedge clk) bus.rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.write, bus.writeaddr, bus.writeop, bus.busy, bus.done, bus.err, bus.cpu_rst_n} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got w=%b a=%h o=%h busy=%b done=%b err=%b crst=%b want all 0",
               bus.write, bus.writeaddr, bus.writeop, bus.busy, bus.done, bus.err, bus.cpu_rst_n);
    end
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (wa_q.size() != 2 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got nwr=%0d busy=%b err=%b want 2 0 0", wa_q.size(), bus.busy, bus.err);
    end
    clear_mon();
    s = '{8'hA5, 8'h01, 8'h7E, 8'h7E};
    send_stream(s, 2);
    checks++;
    if (bus.done !== 1'b1 || wa_q.size() != 1) begin
      errors++;
      $display("FAIL post_reset_load: got done=%b nwr=%0d want 1 1", bus.done, wa_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    logic [7:0] b;
    int n;
    int sum;
    for (int it = 0; it < 6; it++) begin
      clear_mon();
      s.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom_range(0, 255));
        s.push_back((b == 8'hA5) ? 8'h00 : b);
      end
      n = int'($urandom_range(1, 6));
      s.push_back(8'hA5);
      s.push_back(n[7:0]);
      sum = 0;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        s.push_back(b);
        sum += int'(b);
      end
      b = sum[7:0];
      if ($urandom_range(0, 1) == 0) b = b + 8'($urandom_range(1, 255));
      s.push_back(b);
      model_stream(s);
      send_stream(s, 8);
      checks++;
      if (wa_q.size() != exp_a.size()) begin
        errors++;
        $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wa_q.size(), exp_a.size());
      end
      for (int k = 0; k < exp_a.size() && k < wa_q.size(); k++) begin
        checks++;
        if (wa_q[k] !== exp_a[k] || wo_q[k] !== exp_o[k]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %h=%h want %h=%h", it, k, wa_q[k], wo_q[k], exp_a[k], exp_o[k]);
        end
      end
      checks++;
      if (bus.done !== exp_done || bus.err !== exp_err || bus.busy !== 1'b0 || bus.cpu_rst_n !== exp_done) begin
        errors++;
        $display("FAIL rand%0d_status: got done=%b err=%b busy=%b crst=%b want %b %b 0 %b",
                 it, bus.done, bus.err, bus.busy, bus.cpu_rst_n, exp_done, exp_err, exp_done);
      end
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_leading_junk();
    test_wrap_256();
    test_timeout();
    test_frame_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
